// File: rtl/port_pkg.sv
// Shared definitions for the input-port buffer: mode encodings, default
// geometry and a constant log2 helper used to size FIFO pointers and counters.
package port_pkg;

  // Per-channel operating mode, 8255 style.
  typedef enum logic {
    PORT_MODE_BASIC    = 1'b0,
    PORT_MODE_STROBED  = 1'b1
  } port_mode_e;

  localparam int unsigned PORT_DEFAULT_WIDTH = 8;
  localparam int unsigned PORT_DEFAULT_DEPTH = 4;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned pwr;
    res = 0;
    pwr = 1;
    while (pwr < value) begin
      pwr = pwr << 1;
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/port_in_fifo.sv
// Single-channel synchronous FIFO for strobed-mode capture.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   flush_i         empties the FIFO (pointers and count to 0), wins over push/pop
//   push_i, pop_i   requests; push on full is accepted only alongside a pop
//   wdata_i         data written at the tail on an accepted push
//   head_o          entry at the head
//   head_next_o     entry one past the head (new head after a pop)
//   count_o         number of stored entries, 0..DEPTH
//   full_o, empty_o status derived from count
//   push_ok_o       push accepted this cycle
//   pop_ok_o        pop accepted this cycle
module port_in_fifo
  import port_pkg::*;
#(
  parameter  int unsigned WIDTH = PORT_DEFAULT_WIDTH,
  parameter  int unsigned DEPTH = PORT_DEFAULT_DEPTH,
  localparam int unsigned PW    = clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic [WIDTH-1:0] head_next_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             push_ok_o,
  output logic             pop_ok_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

  // A pop frees a slot in the same cycle, so a push on full is taken with it.
  assign pop_ok_o  = ~flush_i & pop_i & ~empty_o;
  assign push_ok_o = ~flush_i & push_i & (~full_o | pop_ok_o);

  assign head_o      = mem_q[rd_ptr_q];
  assign head_next_o = mem_q[rd_ptr_q + PW'(1)];

  // Pointer/count next state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok_o) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok_o)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_ok_o) - CW'(pop_ok_o);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok_o) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/port_in_buf.sv
// Multi-channel 8255-style input port buffer. Each channel runs either as a
// basic latch (mode 0) or as a strobed FIFO with IBF/INTR handshake (mode 1).
// Optional feature macro: PORT_IN_OVF_EN enables the sticky overflow flag and
// its contribution to intr; without it ovf reads 0 and dropped pushes vanish.
// Ports (NCH channels, channel c at bit c / slice [c*WIDTH +: WIDTH]):
//   clk, reset   clock, synchronous active-high reset
//   mode         0 = basic latch, 1 = strobed FIFO
//   port_in      external port data
//   ld_n         mode 0 load enable, active-low
//   stb_n        mode 1 strobe, active-low; its falling edge pushes port_in
//   rd           CPU read pulse, pops in mode 1
//   inte         interrupt enable
//   data_out     registered value for the CPU read mux
//   ibf          FIFO non-empty
//   intr         registered interrupt request
//   full         FIFO full
//   ovf          sticky overflow flag
//   ovf_clr      clears ovf
module port_in_buf
  import port_pkg::*;
#(
  parameter int unsigned WIDTH = PORT_DEFAULT_WIDTH,
  parameter int unsigned DEPTH = PORT_DEFAULT_DEPTH,
  parameter int unsigned NCH   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       mode,
  input  logic [NCH*WIDTH-1:0] port_in,
  input  logic [NCH-1:0]       ld_n,
  input  logic [NCH-1:0]       stb_n,
  input  logic [NCH-1:0]       rd,
  input  logic [NCH-1:0]       inte,
  output logic [NCH*WIDTH-1:0] data_out,
  output logic [NCH-1:0]       ibf,
  output logic [NCH-1:0]       intr,
  output logic [NCH-1:0]       full,
  output logic [NCH-1:0]       ovf,
  input  logic [NCH-1:0]       ovf_clr
);

  localparam int unsigned CW = clog2(DEPTH) + 1;

`ifndef PORT_IN_OVF_EN
  logic unused_ovf_clr;
  assign unused_ovf_clr = ^ovf_clr;
`endif

  for (genvar c = 0; c < int'(NCH); c++) begin : g_ch
    logic             strobed;
    logic             push, pop, flush;
    logic             stb_q;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             intr_q, intr_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] unused_head;
    logic [WIDTH-1:0] head_next;
    logic [CW-1:0]    count;
    logic             f_full, f_empty, push_ok, pop_ok;

    assign din     = port_in[c*WIDTH +: WIDTH];
    assign strobed = (port_mode_e'(mode[c]) == PORT_MODE_STROBED);

    // Falling edge of stb_n against the history register; one push per low period.
    assign push  = strobed & stb_q & ~stb_n[c];
    assign pop   = strobed & rd[c];
    // Basic mode keeps the FIFO empty, which also gives 1->0 flush and 0->1 empty start.
    assign flush = ~strobed;

    port_in_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (flush),
      .push_i      (push),
      .pop_i       (pop),
      .wdata_i     (din),
      .head_o      (unused_head),
      .head_next_o (head_next),
      .count_o     (count),
      .full_o      (f_full),
      .empty_o     (f_empty),
      .push_ok_o   (push_ok),
      .pop_ok_o    (pop_ok)
    );

`ifdef PORT_IN_OVF_EN
    logic drop;
    assign drop = push & ~push_ok;
`endif

    // data_out tracks the post-update head so it lands with the same edge as ibf.
    always_comb begin
      dout_d = dout_q;
      intr_d = 1'b0;
      ovf_d  = ovf_q;
      if (!strobed) begin
        if (!ld_n[c]) dout_d = din;
      end else begin
        if (push_ok && f_empty) begin
          dout_d = din;
        end else if (pop_ok && (count == CW'(1))) begin
          // Last entry leaves: new head is the simultaneous push, else hold.
          if (push_ok) dout_d = din;
        end else if (pop_ok) begin
          dout_d = head_next;
        end
        intr_d = inte[c] & ~f_empty & ~rd[c];
      end
`ifdef PORT_IN_OVF_EN
      if (ovf_clr[c]) ovf_d = 1'b0;
      if (drop)       ovf_d = 1'b1;
      if (strobed && ovf_q && inte[c]) intr_d = 1'b1;
`else
      ovf_d = 1'b0;
`endif
    end

    // Channel registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        stb_q  <= 1'b1;
        dout_q <= '0;
        intr_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else begin
        stb_q  <= stb_n[c];
        dout_q <= dout_d;
        intr_q <= intr_d;
        ovf_q  <= ovf_d;
      end
    end

    assign data_out[c*WIDTH +: WIDTH] = dout_q;
    assign ibf[c]  = ~f_empty;
    assign full[c] = f_full;
    assign intr[c] = intr_q;
    assign ovf[c]  = ovf_q;
  end

endmodule

// File: doc/port_in_buf.md
Name: port_in_buf

Overview:
Parametrised successor to the single 8-bit port-A input latch of the 8255A-style peripheral. It serves any of NCH identical input ports and supports two modes: 8255 mode 0 (basic latched input) and mode 1 (strobed input with IBF/INTR handshake). Mode 1 captures into a per-channel FIFO of depth DEPTH. It sits between the external port pins and the CPU read mux of the counter/PPI design.

Parameters:
WIDTH, 8, data bits per port
DEPTH, 4, strobed-mode FIFO entries per channel (power of 2, >=2)
NCH, 1, number of independent input ports

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high; clears all state
mode  in  NCH  per channel: 0 = basic latch, 1 = strobed FIFO
port_in  in  NCH*WIDTH  external port data, channel c at [c*WIDTH +: WIDTH]
ld_n  in  NCH  mode 0 load enable, active-low
stb_n  in  NCH  mode 1 peripheral strobe, active-low, synchronous to clk
rd  in  NCH  CPU read pulse, one cycle, pops the FIFO in mode 1
inte  in  NCH  interrupt enable per channel
data_out  out  NCH*WIDTH  value presented to the CPU read mux
ibf  out  NCH  input buffer full (FIFO non-empty) in mode 1
intr  out  NCH  interrupt request
full  out  NCH  FIFO full
ovf  out  NCH  sticky overflow flag (see Optional Feature)
ovf_clr  in  NCH  clears ovf

Behaviour:
- Reset values: data_out=0, ibf=0, intr=0, full=0, ovf=0; FIFO pointers and count are 0; the stb_n history register is 1.
- The reset pin is sampled only on the clk edge. Reset mid-transfer discards FIFO contents.
- Mode 0, per channel:
  - While ld_n=0, data_out <= port_in on each edge (1-cycle latency).
  - While ld_n=1, data_out holds.
  - ibf=0, full=0, intr=0. stb_n and rd are ignored.
- Mode 1, push:
  - A push is a falling edge of stb_n: previous sample 1, current 0.
  - On a push, the port_in value sampled in that same cycle is written at the tail.
  - Exactly one push per strobe low period, regardless of its length.
- Mode 1, pop: rd=1 while count>0 advances the head. rd while empty is ignored.
- Mode 1, data_out:
  - data_out is registered: data_out <= head entry on the edge after any push-into-empty or pop.
  - Read latency from strobe edge to data_out is 1 cycle.
  - When the FIFO is empty, data_out holds the last value.
- Mode 1 flags:
  - ibf = (count != 0).
  - full = (count == DEPTH).
  - intr = inte & ibf & ~rd, registered. It deasserts in the cycle after rd and re-asserts the following cycle if data remains.
- Simultaneous push and pop:
  - Both occur and count is unchanged.
  - When full, the pop frees the slot, so the push is accepted.
  - When empty, the push is accepted and the pop is ignored.
- Push while full with no pop: the data is dropped, count is unchanged, and ovf is set when enabled.
- Pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits wide.
- Mode change 1->0 flushes the FIFO: count=0, ibf=0. data_out holds until the next ld_n=0. Change 0->1 starts with an empty FIFO.
- Channels are fully independent. There is no arbitration.

Optional Feature:
PORT_IN_OVF_EN
- Defined:
  - ovf[c] is set on a dropped push.
  - ovf[c] is cleared by ovf_clr[c]. Set wins if both occur in the same cycle.
  - In mode 1, intr additionally asserts while ovf & inte.
- Undefined:
  - ovf is tied to 0 and ovf_clr is unused.
  - A dropped push is silently discarded.

Decomposition:
- Package port_pkg holds:
  - mode encodings: PORT_MODE_BASIC=1'b0, PORT_MODE_STROBED=1'b1
  - default WIDTH/DEPTH constants
  - the function clog2 for counter widths
- Sub-module port_in_fifo: a single-channel synchronous FIFO with push, pop, flush, count, full and empty.
- The top level generates NCH channel slices. Each slice contains port_in_fifo plus mode/latch/handshake logic.

Test Plan:
1. Mode 0, WIDTH=8: port_in=8'hA5, ld_n=0 for one cycle, then ld_n=1 and port_in=8'h3C -> data_out=8'hA5 from the next cycle and holds; ibf=0.
2. Mode 1, inte=1: strobe a falling edge with 8'h11, hold stb_n low 5 cycles -> exactly one entry; ibf=1, data_out=8'h11, intr=1. Then rd -> ibf=0, intr=0.
3. Mode 1, DEPTH=4: strobe 8'h01..8'h04 -> full=1. A fifth strobe with 8'h05 -> dropped, ovf=1 (macro defined). Four rds -> data_out 01,02,03,04 in order.
4. Full FIFO: strobe 8'h99 and rd in the same cycle -> count stays 4, 8'h99 is read last.
5. Reset asserted with 3 entries queued -> next cycle ibf=0, intr=0, full=0, data_out=0, ovf=0.
6. NCH=2: channel 0 in mode 0, channel 1 in mode 1, with interleaved ld_n and stb_n -> no cross-channel interference; channel 1 intr is independent of channel 0.
